// File: rtl/visl_pkg.sv
// Shared widths, signed types and limits for the MAC accumulator datapath.
package visl_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int LEN_W  = 12;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } out_state_e;

    // Saturating +1 for the beat counter.
    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

endpackage

// File: rtl/mac_mul_stage.sv
// Stage 1: registered full-width signed multiply with valid/last pass-through.
module mac_mul_stage
    import visl_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    output logic signed [2*DW-1:0] p_o,
    output logic                   valid_o,
    output logic                   last_o
);

    logic signed [2*DW-1:0] p_q, p_d;
    logic                   v_q, v_d;
    logic                   l_q, l_d;

    always_comb begin
        p_d = p_q;
        v_d = v_q;
        l_d = l_q;
        if (en_i) begin
            v_d = valid_i;
            l_d = last_i;
            // Product register only toggles on real beats.
            if (valid_i) begin
                p_d = a_i * b_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_q <= '0;
            v_q <= 1'b0;
            l_q <= 1'b0;
        end else begin
            p_q <= p_d;
            v_q <= v_d;
            l_q <= l_d;
        end
    end

    assign p_o     = p_q;
    assign valid_o = v_q;
    assign last_o  = l_q;

endmodule

// File: rtl/mac_accumulator.sv
// Signed dot-product accumulator: multiply stage, accumulate stage, result hold FSM.
// Build option MAC_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
//
// state   | meaning
// ST_ACC  | no result pending; accumulating beats
// ST_HOLD | result presented on out_*, waiting for out_ready_i
module mac_accumulator
    import visl_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ACC_W,
    parameter int LW = LEN_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    input  logic                 last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic signed [AW-1:0] out_data_o,
    output logic [LW-1:0]        out_len_o,
    output logic                 ovf_o
);

    out_state_e state_q, state_d;

    logic                   en;
    logic                   xfer;
    logic signed [2*DW-1:0] p1;
    logic                   v1, l1;

    logic signed [AW-1:0] acc_q, acc_d, acc_res;
    logic [LW-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                 ovf_q, ovf_d, ovf_acc;
    logic signed [AW:0]   p_ext, sum_w;
    logic                 ovf_beat;
    logic                 load;

    logic signed [AW-1:0] out_data_q, out_data_d;
    logic [LW-1:0]        out_len_q, out_len_d;
    logic                 out_ovf_q, out_ovf_d;

    assign en         = ~(out_valid_o & ~out_ready_i);
    assign in_ready_o = en;
    assign xfer       = in_valid_i & en;

    mac_mul_stage #(.DW(DW)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en),
        .valid_i (xfer),
        .last_i  (last_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .p_o     (p1),
        .valid_o (v1),
        .last_o  (l1)
    );

    // One guard bit above AW exposes overflow of the signed sum.
    assign p_ext    = {{(AW+1-2*DW){p1[2*DW-1]}}, p1};
    assign sum_w    = {acc_q[AW-1], acc_q} + p_ext;
    assign ovf_beat = sum_w[AW] ^ sum_w[AW-1];
    assign ovf_acc  = ovf_q | ovf_beat;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + LW'(1);
    assign load     = en & v1 & l1;

`ifdef MAC_ACC_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};
    assign acc_res = ovf_beat ? (sum_w[AW] ? SAT_MIN : SAT_MAX) : sum_w[AW-1:0];
`else
    assign acc_res = sum_w[AW-1:0];
`endif

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_len_d  = out_len_q;
        out_ovf_d  = out_ovf_q;
        if (en & v1) begin
            if (l1) begin
                // Final beat: publish and restart the vector in the same cycle.
                out_data_d = acc_res;
                out_len_d  = cnt_inc;
                out_ovf_d  = ovf_acc;
                acc_d      = '0;
                cnt_d      = '0;
                ovf_d      = 1'b0;
            end else begin
                acc_d = acc_res;
                cnt_d = cnt_inc;
                ovf_d = ovf_acc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_len_q  <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_len_q  <= out_len_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: begin
                if (load) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_d = load ? ST_HOLD : ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_comb begin
        out_valid_o = (state_q == ST_HOLD);
    end

    assign out_data_o = out_data_q;
    assign out_len_o  = out_len_q;
    assign ovf_o      = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a reference model and per-cycle output checking.
module tb_mac_accumulator;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic signed [15:0] a_i;
    logic signed [15:0] b_i;
    logic               last_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic signed [31:0] out_data_o;
    logic [11:0]        out_len_o;
    logic               ovf_o;

    mac_accumulator dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .last_i      (last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_len_o   (out_len_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc_cyc = 0;

    always @(posedge clk_i) cyc++;

    typedef struct {
        longint data;
        int     len;
        bit     ovf;
    } exp_t;

    exp_t   q[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_ovf = 0;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model and compare process: outputs sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_i) begin
            m_acc = 0;
            m_cnt = 0;
            m_ovf = 0;
            q.delete();
        end else begin
            check("in_ready_rule", in_ready_o, !(out_valid_o && !out_ready_i));
            if (out_valid_o) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result actual=%0d required=none", out_data_o);
                end else begin
                    check("model_data", out_data_o, q[0].data);
                    check("model_len", out_len_o, q[0].len);
                    check("model_ovf", ovf_o, q[0].ovf);
                    if (out_ready_i) void'(q.pop_front());
                end
            end
            if (in_valid_i && in_ready_o) begin
                longint s;
                bit ov;
                s  = m_acc + longint'(a_i) * longint'(b_i);
                ov = (s > MAXV) || (s < MINV);
`ifdef MAC_ACC_SATURATE_EN
                if (s > MAXV) s = MAXV;
                if (s < MINV) s = MINV;
`else
                s = longint'(int'(s));
`endif
                m_ovf = m_ovf | ov;
                m_cnt = (m_cnt < 4095) ? m_cnt + 1 : 4095;
                if (last_i) begin
                    q.push_back('{data: s, len: m_cnt, ovf: m_ovf});
                    last_acc_cyc = cyc;
                    m_acc = 0;
                    m_cnt = 0;
                    m_ovf = 0;
                end else begin
                    m_acc = s;
                end
            end
        end
    end

    task automatic send(input int a, input int b, input bit l);
        bit ok;
        ok = 0;
        in_valid_i = 1'b1;
        a_i = a[15:0];
        b_i = b[15:0];
        last_i = l;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        last_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (out_valid_o) begin
                lat = cyc - last_acc_cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL wait_valid_timeout actual=0 required=1");
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        longint big_exp;
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        a_i = '0;
        b_i = '0;
        last_i = 1'b0;
        out_ready_i = 1'b0;
        idle(3);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_out_len", out_len_o, 0);
        check("rst_ovf", ovf_o, 0);
        rst_i = 1'b0;
        out_ready_i = 1'b1;

        send(100, 200, 0);
        send(-50, 300, 0);
        send(7, 7, 1);
        wait_valid(lat);
        check("v1_latency", lat, 2);
        check("v1_data", out_data_o, 5049);
        check("v1_len", out_len_o, 3);
        check("v1_ovf", ovf_o, 0);
        idle(3);

        send(-32768, -32768, 1);
        wait_valid(lat);
        check("minmin_data", out_data_o, 1073741824);
        check("minmin_len", out_len_o, 1);
        check("minmin_ovf", ovf_o, 0);
        idle(3);

        send(32767, 32767, 0);
        send(32767, 32767, 0);
        send(32767, 32767, 1);
        wait_valid(lat);
`ifdef MAC_ACC_SATURATE_EN
        big_exp = 2147483647;
`else
        big_exp = -1073938429;
`endif
        check("ovf_data", out_data_o, big_exp);
        check("ovf_len", out_len_o, 3);
        check("ovf_flag", ovf_o, 1);
        idle(3);

        out_ready_i = 1'b0;
        send(3, 4, 1);
        wait_valid(lat);
        check("stall_data0", out_data_o, 12);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check("stall_in_ready", in_ready_o, 0);
            check("stall_valid", out_valid_o, 1);
            check("stall_data", out_data_o, 12);
            check("stall_len", out_len_o, 1);
        end
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        #1;
        check("release_in_ready", in_ready_o, 1);
        idle(3);
        check("after_release_valid", out_valid_o, 0);

        send(2, 3, 1);
        send(4, 5, 1);
        wait_valid(lat);
        check("b2b_first_data", out_data_o, 6);
        check("b2b_first_len", out_len_o, 1);
        @(negedge clk_i);
        check("b2b_second_valid", out_valid_o, 1);
        check("b2b_second_data", out_data_o, 20);
        check("b2b_second_len", out_len_o, 1);
        idle(3);

        send(9, 9, 0);
        send(8, 8, 0);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        send(1, 1, 1);
        wait_valid(lat);
        check("rst_mid_data", out_data_o, 1);
        check("rst_mid_len", out_len_o, 1);
        check("rst_mid_ovf", ovf_o, 0);
        idle(5);
        check("final_valid", out_valid_o, 0);
        check("final_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
